ring_arbiter: RTL and testbench
===============================

# ring_arbiter

Round-robin arbiter that shares one resource (e.g., a counter datapath or shared bus port) among N requesters. A one-hot rotating priority pointer, a ring counter that advances past each winner, ensures fair service. The grant is registered and held until the owner signals `done`. The block sits between the requesting clients and the shared datapath, and is the sequencing layer above the team's ring-counter primitives.

## Interface
- `N`, default 4: number of requesters; must be ≥ 2.
- `MAX_HOLD`, default 16: maximum grant duration in cycles. Used only when the watchdog is compiled in; must be ≥ 1.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req`, input, N: request vector; bit i is requester i.
- `done`, input, 1: current owner releases the resource; sampled only while busy.
- `grant`, output, N: one-hot grant, or all-zero when idle.
- `gnt_id`, output, $clog2(N): binary index of the granted bit; 0 when idle.
- `busy`, output, 1: high while any grant is asserted.
- `tout`, output, 1: one-cycle pulse on watchdog forced release.

## Operation
- States: IDLE and HOLD.
- **Reset values** (asynchronous, immediate):
  - state = IDLE
  - `grant` = 0
  - `gnt_id` = 0
  - `busy` = 0
  - `tout` = 0
  - priority pointer `ptr` = one-hot bit 0
  - hold counter = 0
- **Winner search:** scan `req` from the bit at the search base upward, wrapping from bit N-1 to bit 0. The first set bit wins.
  - Search base = `ptr` in IDLE.
  - Search base = rotate-left-by-1 of the current `grant` on release in HOLD.
- **IDLE → HOLD:** taken when `req` ≠ 0.
  - `grant` is set to the winner.
  - `ptr` is set to rotate-left-by-1 of the winner.
- **HOLD:** `grant` is held constant.
  - Deasserting the owner's `req` does not release the grant; only `done` (or the watchdog) releases it.
- **Release in HOLD (`done`=1):**
  - If `req` has any bit set, including the current owner's, grant the next winner immediately. This is a back-to-back handoff and `ptr` updates.
  - Otherwise go to IDLE with `grant` = 0.
- **`done` in IDLE:** ignored.
- **Pointer invariant:** `ptr` is always exactly one-hot. It changes only when a new grant is issued.
- **Derived outputs:** `gnt_id` and `busy` are registered alongside `grant` and are never combinationally derived from `req`.
- **Hold counter:**
  - Cleared on every new grant.
  - Increments each HOLD cycle.
  - Width is $clog2(MAX_HOLD+1).

## Timing
- **Request-to-grant latency:** 1 cycle. A `req` sampled at edge k in IDLE gives `grant` valid after edge k.
- **Release:**
  - A `done` sampled at edge k changes `grant` after edge k, either to 0 or to the next owner.
  - There is no dead cycle between owners when requests are pending.
- **Minimum tenure:** 1 cycle. `done` may be high in the first grant cycle.
- **Ownership:** `grant` never has more than one bit set, and never changes within a cycle except through `rst`.
- **Reset mid-operation:** `grant` drops to 0 asynchronously. The first grant after reset deassertion follows the IDLE rule with `ptr` = bit 0.

## Configuration
- `RING_ARBITER_TIMEOUT_EN` defined: the watchdog is compiled in.
  - When the hold counter reaches MAX_HOLD in HOLD with `done`=0, a forced release occurs, treated exactly as `done`=1 (handoff or IDLE).
  - `tout` pulses high for that one cycle, registered with the new `grant`.
  - `done` and timeout in the same cycle count as a normal release with `tout`=0.
- `RING_ARBITER_TIMEOUT_EN` undefined:
  - No hold counter is built.
  - `tout` is tied to 0.
  - A grant is held indefinitely until `done`.

## Structure
- Package `ring_arbiter_pkg` holds:
  - the state enum `arb_state_t` (ARB_IDLE, ARB_HOLD)
  - the one-hot rotate-left function
  - the one-hot-to-binary function
- Sub-module `rr_pick`: combinational wrapped priority search (inputs `req` and base one-hot; output winner one-hot).
- The top level holds the FSM, `ptr`, the grant registers, and the watchdog.

## Test plan
- **Reset:** hold `rst`=1 with `req`=1111 → `grant`=0000, `busy`=0, `gnt_id`=0, `tout`=0. Assert `rst` mid-HOLD → `grant`=0000 before the next edge.
- **Single requester:** `req`=0100 in IDLE → `grant`=0100, `gnt_id`=2 one cycle later. `done` pulse → `grant`=0000, `busy`=0.
- **Full rotation:** `req`=1111 with `done` high every cycle → `grant` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- **Wrap-around search:** after a grant to bit 2 is released, `req`=0101 → next `grant`=0001 (bit 3 empty, wraps to bit 0).
- **Sticky grant:** owner on bit 1 drops `req` with `done`=0 for 5 cycles → `grant` stays 0010 throughout.
- **Watchdog** (macro defined, MAX_HOLD=16): `req`=0011, `done`=0 → `grant`=0001 held for 16 cycles, then `grant`=0010 with a one-cycle `tout`=1. With the macro undefined, the same stimulus keeps `grant`=0001 for more than 100 cycles and `tout`=0.

Source files
------------

// File: rtl/ring_arbiter_pkg.sv
// Shared types and one-hot helpers for ring_arbiter and rr_pick.
// Helpers operate on MAX_N-bit vectors; callers size-cast to their own N.
package ring_arbiter_pkg;

   localparam int unsigned MAX_N = 32;
   localparam int unsigned MAX_W = 5;

   typedef enum logic {
      ARB_IDLE,
      ARB_HOLD
   } arb_state_t;

   // Rotate a one-hot vector left by one within its low n bits.
   function automatic logic [MAX_N-1:0] oh_rotl(input logic [MAX_N-1:0] v, input int unsigned n);
      logic [MAX_N-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (i < n && v[i]) begin
            if (i + 1 == n) r[0] = 1'b1;
            else            r[i+1] = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [MAX_W-1:0] oh2bin(input logic [MAX_N-1:0] v);
      logic [MAX_W-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (v[i]) b = b | MAX_W'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/ring_arbiter_pick.sv
// rr_pick: combinational wrapped priority search starting at a one-hot base.
module rr_pick
   import ring_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] base,
   output logic [N-1:0] win
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [MAX_W-1:0] base_idx;
   logic [W-1:0]     sel;
   logic             found;

   assign base_idx = oh2bin(MAX_N'(base));

   always_comb begin
      int unsigned idx;
      win   = '0;
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(base_idx) + k;
         if (idx >= N) idx = idx - N;
         sel = W'(idx);
         if (!found && req[sel]) begin
            win[sel] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with registered, held grant and rotating one-hot pointer.
// Optional hold watchdog enabled by defining RING_ARBITER_TIMEOUT_EN.
module ring_arbiter
   import ring_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 tout
);

   localparam int W = $clog2(N);

   generate
      if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_bad_cfg
         $error("ring_arbiter: unsupported N or MAX_HOLD");
      end
   endgenerate

   arb_state_t   state;
   logic [N-1:0] ptr;
   logic [N-1:0] base;
   logic [N-1:0] win;
   logic [N-1:0] win_ptr;
   logic [W-1:0] win_id;
   logic         expire;

   // On release the search restarts just past the current owner, not at ptr.
   assign base    = (state == ARB_HOLD) ? N'(oh_rotl(MAX_N'(grant), N)) : ptr;
   assign win_id  = W'(oh2bin(MAX_N'(win)));
   assign win_ptr = N'(oh_rotl(MAX_N'(win), N));

   rr_pick #(.N(N)) u_pick (
      .req  (req),
      .base (base),
      .win  (win)
   );

`ifdef RING_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] hold_cnt;
   logic          tout_r;
   assign expire = (hold_cnt == CW'(MAX_HOLD - 1));
   assign tout   = tout_r;
`else
   assign expire = 1'b0;
   assign tout   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         gnt_id <= '0;
         busy   <= 1'b0;
         ptr    <= N'(1);
`ifdef RING_ARBITER_TIMEOUT_EN
         hold_cnt <= '0;
         tout_r   <= 1'b0;
`endif
      end else begin
`ifdef RING_ARBITER_TIMEOUT_EN
         tout_r <= 1'b0;
`endif
         case (state)
            ARB_IDLE: begin
               if (|req) begin
                  state  <= ARB_HOLD;
                  grant  <= win;
                  gnt_id <= win_id;
                  busy   <= 1'b1;
                  ptr    <= win_ptr;
`ifdef RING_ARBITER_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end
            end
            ARB_HOLD: begin
               if (done || expire) begin
`ifdef RING_ARBITER_TIMEOUT_EN
                  tout_r <= ~done;
`endif
                  if (|req) begin
                     grant  <= win;
                     gnt_id <= win_id;
                     ptr    <= win_ptr;
`ifdef RING_ARBITER_TIMEOUT_EN
                     hold_cnt <= '0;
`endif
                  end else begin
                     state  <= ARB_IDLE;
                     grant  <= '0;
                     gnt_id <= '0;
                     busy   <= 1'b0;
                  end
               end else begin
`ifdef RING_ARBITER_TIMEOUT_EN
                  hold_cnt <= hold_cnt + CW'(1);
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ring_arbiter.sv
// Scoreboard bench for ring_arbiter (N=4, MAX_HOLD=16); honours RING_ARBITER_TIMEOUT_EN.
module tb_ring_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 16;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] grant;
   logic [1:0]   gnt_id;
   logic         busy;
   logic         tout;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb_q[$];

   // reference model state
   logic [N-1:0] m_grant;
   logic [N-1:0] m_ptr;
   logic         m_busy;
   logic         m_tout;
   int           m_cnt;

   ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .done   (done),
      .grant  (grant),
      .gnt_id (gnt_id),
      .busy   (busy),
      .tout   (tout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL time_limit got running expected finished");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
      return {v[N-2:0], v[N-1]};
   endfunction

   function automatic logic [N-1:0] search(input logic [N-1:0] r, input logic [N-1:0] b);
      logic [N-1:0] v;
      v = b;
      for (int i = 0; i < N; i++) begin
         if ((r & v) != '0) return v;
         v = rotl(v);
      end
      return '0;
   endfunction

   function automatic logic [1:0] idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic model_step();
      logic [N-1:0] w;
      logic         ex;
      if (rst) begin
         m_grant = '0; m_ptr = 4'b0001; m_busy = 1'b0; m_tout = 1'b0; m_cnt = 0;
      end else begin
         m_tout = 1'b0;
         if (!m_busy) begin
            if (req != '0) begin
               w = search(req, m_ptr);
               m_grant = w; m_ptr = rotl(w); m_busy = 1'b1; m_cnt = 0;
            end
         end else begin
            ex = 1'b0;
`ifdef RING_ARBITER_TIMEOUT_EN
            ex = (m_cnt == MAX_HOLD - 1);
`endif
            if (done || ex) begin
               m_tout = ex && !done;
               if (req != '0) begin
                  w = search(req, rotl(m_grant));
                  m_grant = w; m_ptr = rotl(w); m_cnt = 0;
               end else begin
                  m_grant = '0; m_busy = 1'b0;
               end
            end else begin
               m_cnt++;
            end
         end
      end
      sb_q.push_back({m_tout, m_busy, idx_of(m_grant), m_grant});
   endtask

   task automatic cycle();
      logic [7:0] exp;
      @(posedge clk);
      model_step();
      #1;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 8'd0, 8'd1);
      end else begin
         exp = sb_q.pop_front();
         check_eq("sb", {tout, busy, gnt_id, grant}, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] rot_exp[5];
      rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
      rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

      rst = 1'b1; req = 4'b1111; done = 1'b0;
      #2;
      repeat (3) cycle();
      check_eq("rst_grant", 8'(grant), 8'h00);
      check_eq("rst_busy", 8'(busy), 8'h00);
      check_eq("rst_id", 8'(gnt_id), 8'h00);
      check_eq("rst_tout", 8'(tout), 8'h00);
      rst = 1'b0;

      // single requester
      req = 4'b0100; done = 1'b0; cycle();
      check_eq("single_grant", 8'(grant), 8'h04);
      check_eq("single_id", 8'(gnt_id), 8'h02);
      req = 4'b0000; done = 1'b1; cycle();
      check_eq("single_rel", 8'(grant), 8'h00);
      check_eq("single_busy", 8'(busy), 8'h00);

      // full rotation from a fresh pointer
      do_reset();
      req = 4'b1111; done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_eq($sformatf("rot%0d", i), 8'(grant), 8'(rot_exp[i]));
      end
      req = 4'b0000; cycle();

      // wrap-around search
      req = 4'b0100; done = 1'b0; cycle();
      check_eq("wrap_pre", 8'(grant), 8'h04);
      req = 4'b0000; done = 1'b1; cycle();
      req = 4'b0101; done = 1'b0; cycle();
      check_eq("wrap_grant", 8'(grant), 8'h01);
      req = 4'b0000; done = 1'b1; cycle();

      // sticky grant
      req = 4'b0010; done = 1'b0; cycle();
      check_eq("sticky_first", 8'(grant), 8'h02);
      req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check_eq($sformatf("sticky%0d", i), 8'(grant), 8'h02);
      end
      done = 1'b1; cycle();
      check_eq("sticky_rel", 8'(busy), 8'h00);

      // random traffic, scoreboard only
      for (int i = 0; i < 200; i++) begin
         req  = 4'($urandom);
         done = ($urandom_range(0, 3) == 0);
         cycle();
      end

      // watchdog / indefinite hold
      done = 1'b0; req = 4'b0000; cycle(); cycle();
      do_reset();
      req = 4'b0011; done = 1'b0; cycle();
      check_eq("wd_first", 8'(grant), 8'h01);
`ifdef RING_ARBITER_TIMEOUT_EN
      for (int i = 1; i < MAX_HOLD; i++) begin
         cycle();
         check_eq($sformatf("wd_hold%0d", i), {3'b0, tout, grant}, 8'h01);
      end
      cycle();
      check_eq("wd_fire", {3'b0, tout, grant}, 8'h12);
      cycle();
      check_eq("wd_pulse_end", 8'(tout), 8'h00);
`else
      for (int i = 0; i < 110; i++) begin
         cycle();
         check_eq($sformatf("nowd%0d", i), {3'b0, tout, grant}, 8'h01);
      end
`endif

      // asynchronous reset mid-HOLD
      check_eq("mid_busy", 8'(busy), 8'h01);
      rst = 1'b1;
      #1;
      check_eq("async_grant", 8'(grant), 8'h00);
      check_eq("async_busy", 8'(busy), 8'h00);
      cycle();
      rst = 1'b0; req = 4'b1111; done = 1'b0; cycle();
      check_eq("post_rst", 8'(grant), 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
